// File: rtl/ddr_sdram_ex_lfsr_gen_chk.sv
// ddr_sdram_ex_lfsr_gen_chk: Galois LFSR write-pattern generator plus a self-synchronising read-back checker.
// Revision: 1.0
`default_nettype none

module ddr_sdram_ex_lfsr_gen_chk #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'h1D,
    parameter int               SEED        = 32,
    parameter int               LOCK_THRESH = 4,
    parameter int               LOSS_THRESH = 3,
    parameter int               ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 pause,
    input  logic                 load,
    input  logic [WIDTH-1:0]     ldata,
    output logic [WIDTH-1:0]     data,
    input  logic                 chk_valid,
    input  logic [WIDTH-1:0]     chk_data,
    input  logic                 chk_resync,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [WIDTH-1:0]     SEED_V  = WIDTH'(SEED);
    localparam logic [7:0]           LOCK_T  = 8'(LOCK_THRESH);
    localparam logic [7:0]           LOSS_T  = 8'(LOSS_THRESH);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } chk_state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        logic             msb;
        msb  = x[WIDTH-1];
        r    = '0;
        r[0] = msb;
        for (int i = 1; i < WIDTH; i++) begin
            r[i] = x[i-1] ^ (TAPS[i] & msb);
        end
        return r;
    endfunction

    logic [WIDTH-1:0] gen;
    chk_state_t       state;
    logic [WIDTH-1:0] expected;
    logic [7:0]       match_cnt;
    logic [7:0]       miss_cnt;
    logic             err_hit;

    assign data = gen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen <= SEED_V;
        end else if (!enable) begin
            gen <= SEED_V;
        end else if (load) begin
            gen <= ldata;
        end else if (!pause) begin
            gen <= lfsr_next(gen);
        end
    end

    // A mismatching qualified beat while locked; drives both the pulse and the counter.
    assign err_hit = enable && !chk_resync && chk_valid &&
                     (state == ST_LOCKED) && (chk_data != expected);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_UNLOCKED;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= err_hit;
            if (!enable || chk_resync) begin
                state     <= ST_UNLOCKED;
                expected  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b0;
            end else if (chk_valid) begin
                case (state)
                    ST_UNLOCKED: begin
                        if (chk_data != '0) begin
                            expected  <= lfsr_next(chk_data);
                            match_cnt <= '0;
                            state     <= ST_LOCKING;
                        end
                    end
                    ST_LOCKING: begin
                        if (chk_data == expected) begin
                            expected <= lfsr_next(expected);
                            if (match_cnt + 8'd1 >= LOCK_T) begin
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                                locked    <= 1'b1;
                                state     <= ST_LOCKED;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else if (chk_data != '0) begin
                            expected  <= lfsr_next(chk_data);
                            match_cnt <= '0;
                        end else begin
                            expected  <= '0;
                            match_cnt <= '0;
                            state     <= ST_UNLOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-runs on its own prediction; a corrupted beat must not reseed.
                        expected <= lfsr_next(expected);
                        if (chk_data == expected) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt + 8'd1 >= LOSS_T) begin
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            state     <= ST_UNLOCKED;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state    <= ST_UNLOCKED;
                        expected <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (err_hit && (err_count != CNT_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_sdram_ex_lfsr_gen_chk.sv
// tb_ddr_sdram_ex_lfsr_gen_chk: directed checks of the generator and checker, with a 2-bit error counter instance for saturation.
// Revision: 1.0
`default_nettype none

module tb_ddr_sdram_ex_lfsr_gen_chk;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       pause;
    logic       load;
    logic [7:0] ldata;
    logic       chk_valid;
    logic [7:0] chk_data;
    logic       chk_resync;
    logic       err_clr;

    logic [7:0]  data_a,  data_b;
    logic        locked_a, locked_b;
    logic        err_a,    err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] v;

    ddr_sdram_ex_lfsr_gen_chk dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pause(pause),
        .load(load), .ldata(ldata), .data(data_a),
        .chk_valid(chk_valid), .chk_data(chk_data), .chk_resync(chk_resync),
        .err_clr(err_clr), .locked(locked_a), .err(err_a), .err_count(cnt_a)
    );

    ddr_sdram_ex_lfsr_gen_chk #(.ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pause(pause),
        .load(load), .ldata(ldata), .data(data_b),
        .chk_valid(chk_valid), .chk_data(chk_data), .chk_resync(chk_resync),
        .err_clr(err_clr), .locked(locked_b), .err(err_b), .err_count(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference next-state of the default 8-bit pattern, used only to build read-back stimulus.
    function automatic logic [7:0] nxt(input logic [7:0] x);
        return x[7] ? ({x[6:0], 1'b1} ^ 8'h1C) : {x[6:0], 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        chk_valid = 1'b1;
        chk_data  = d;
        step();
    endtask

    task automatic check_chk(input string tag, input logic lk, input logic e,
                             input logic [15:0] ca, input logic [1:0] cb);
        check({tag, "_locked"}, {31'd0, locked_a}, {31'd0, lk});
        check({tag, "_err"},    {31'd0, err_a},    {31'd0, e});
        check({tag, "_cnt"},    {16'd0, cnt_a},    {16'd0, ca});
        check({tag, "_cnt2"},   {30'd0, cnt_b},    {30'd0, cb});
        check({tag, "_lockb"},  {31'd0, locked_b}, {31'd0, lk});
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; pause = 1'b0; load = 1'b0; ldata = 8'h00;
        chk_valid = 1'b0; chk_data = 8'h00; chk_resync = 1'b0; err_clr = 1'b0;
        step(); step();
        check("rst_data", {24'd0, data_a}, 32'h20);
        check_chk("rst", 1'b0, 1'b0, 16'd0, 2'd0);
        reset_n = 1'b1;

        // Free-running generator
        enable = 1'b1;
        step(); check("gen_1", {24'd0, data_a}, 32'h40);
        step(); check("gen_2", {24'd0, data_a}, 32'h80);
        step(); check("gen_3", {24'd0, data_a}, 32'h1D);
        step(); check("gen_4", {24'd0, data_a}, 32'h3A);

        enable = 1'b0;
        step(); check("gen_dis", {24'd0, data_a}, 32'h20);
        enable = 1'b1;
        step(); step(); check("gen_re", {24'd0, data_a}, 32'h80);
        pause = 1'b1;
        step(); check("pause_1", {24'd0, data_a}, 32'h80);
        step(); check("pause_2", {24'd0, data_a}, 32'h80);
        step(); check("pause_3", {24'd0, data_a}, 32'h80);
        pause = 1'b0;
        step(); check("unpause", {24'd0, data_a}, 32'h1D);
        load = 1'b1; pause = 1'b1; ldata = 8'hA5;
        step(); check("load", {24'd0, data_a}, 32'hA5);
        check("load_b", {24'd0, data_b}, 32'hA5);
        load = 1'b0; pause = 1'b0;

        // Acquire lock: one seeding beat plus four matches
        v = 8'h5A;
        beat(v); check_chk("seed", 1'b0, 1'b0, 16'd0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            v = nxt(v);
            beat(v);
            check($sformatf("acq%0d_locked", k), {31'd0, locked_a}, {31'd0, (k == 4)});
            check($sformatf("acq%0d_err", k), {31'd0, err_a}, 32'd0);
        end

        // Single corrupted beat keeps lock
        v = nxt(v); beat(v ^ 8'h01); check_chk("err1", 1'b1, 1'b1, 16'd1, 2'd1);
        v = nxt(v); beat(v);         check_chk("ok1",  1'b1, 1'b0, 16'd1, 2'd1);

        // Three consecutive corruptions drop lock on the third
        v = nxt(v); beat(v ^ 8'h01); check_chk("err2", 1'b1, 1'b1, 16'd2, 2'd2);
        v = nxt(v); beat(v ^ 8'h01); check_chk("err3", 1'b1, 1'b1, 16'd3, 2'd3);
        v = nxt(v); beat(v ^ 8'h01); check_chk("err4", 1'b0, 1'b1, 16'd4, 2'd3);

        chk_valid = 1'b0;
        step(); check_chk("idle", 1'b0, 1'b0, 16'd4, 2'd3);

        // All-zero beats never seed
        beat(8'h00); beat(8'h00); beat(8'h00);
        check_chk("zeros", 1'b0, 1'b0, 16'd4, 2'd3);
        v = nxt(v); beat(v);
        v = nxt(v); beat(v);
        v = nxt(v); beat(v);
        v = nxt(v); beat(v);
        check("relock_pre", {31'd0, locked_a}, 32'd0);
        v = nxt(v); beat(v);
        check("relock", {31'd0, locked_a}, 32'd1);

        // Fifth error: wide counter reaches 5, 2-bit counter stays saturated
        v = nxt(v); beat(v ^ 8'h80); check_chk("err5", 1'b1, 1'b1, 16'd5, 2'd3);

        // Resync drops lock, counter retained
        chk_resync = 1'b1;
        v = nxt(v); beat(v); check_chk("resync", 1'b0, 1'b0, 16'd5, 2'd3);
        chk_resync = 1'b0;

        // Relock, then err_clr wins over a simultaneous increment
        for (int k = 0; k < 5; k++) begin
            v = nxt(v); beat(v);
        end
        check("relock2", {31'd0, locked_a}, 32'd1);
        err_clr = 1'b1;
        v = nxt(v); beat(v ^ 8'h01); check_chk("clr", 1'b1, 1'b1, 16'd0, 2'd0);
        err_clr = 1'b0;
        v = nxt(v); beat(v); check_chk("post_clr", 1'b1, 1'b0, 16'd0, 2'd0);

        // Asynchronous reset during an err pulse
        v = nxt(v); beat(v ^ 8'h01); check_chk("pre_rst", 1'b1, 1'b1, 16'd1, 2'd1);
        reset_n = 1'b0;
        #1;
        check("arst_data", {24'd0, data_a}, 32'h20);
        check_chk("arst", 1'b0, 1'b0, 16'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
